// File: rtl/uart_rx_frame_pkg.sv
// uart_rx_frame_pkg
//   Shared definitions for the 12-bit UART frame (start, D0..D7 LSB first,
//   even-parity bit, two stop bits). Receiver and transmitter both use it.
//   Contents: receiver FSM state encoding, frame geometry constants and the
//   parity helper.
package uart_rx_frame_pkg;

  localparam int DATA_BITS  = 8;
  localparam int STOP_BITS  = 2;
  localparam int FRAME_BITS = 12;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP1     = 3'd4,
    STOP2     = 3'd5,
    WAIT_HIGH = 3'd6
  } rx_state_e;

  // Parity bit value for a data byte: XOR of all data bits, so the nine
  // data+parity bits always carry an even number of ones.
  function automatic logic parity_of(input logic [DATA_BITS-1:0] data);
    return ^data;
  endfunction

endpackage : uart_rx_frame_pkg

// File: rtl/uart_rx_frame_if.sv
// uart_rx_frame_if
//   Groups the serial input and the parallel host-side outputs of the
//   receiver.
//   Signals:
//     Serial_in  - asynchronous serial line, idle high
//     Dataout    - last received byte, D0 in bit 0
//     Valid      - one-cycle pulse when a frame completes
//     Parity_err - parity mismatch of the last frame (held until next Valid)
//     Frame_err  - a stop bit of the last frame was 0 (held until next Valid)
//     Busy       - receiver is not idle
//   Modports:
//     master - the receiver: reads the line, drives the host outputs
//     slave  - line driver / host: drives the line, reads the outputs
interface uart_rx_frame_if;
  import uart_rx_frame_pkg::*;

  logic                 Serial_in;
  logic [DATA_BITS-1:0] Dataout;
  logic                 Valid;
  logic                 Parity_err;
  logic                 Frame_err;
  logic                 Busy;

  modport master (
    input  Serial_in,
    output Dataout,
    output Valid,
    output Parity_err,
    output Frame_err,
    output Busy
  );

  modport slave (
    output Serial_in,
    input  Dataout,
    input  Valid,
    input  Parity_err,
    input  Frame_err,
    input  Busy
  );

endinterface : uart_rx_frame_if

// File: rtl/uart_sync.sv
// uart_sync
//   N-stage synchronizer for the asynchronous serial line. All stages reset
//   to 1 so that a reset never looks like a start bit.
//   Ports:
//     Clk     - system clock
//     Rst_n   - synchronous active-low reset
//     async_i - asynchronous input
//     sync_o  - synchronized output (last stage)
module uart_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic Clk,
  input  logic Rst_n,
  input  logic async_i,
  output logic sync_o
);

  logic [SYNC_STAGES-1:0] ff_q;

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      ff_q <= '1;
    end else begin
      ff_q <= {ff_q[SYNC_STAGES-2:0], async_i};
    end
  end

  assign sync_o = ff_q[SYNC_STAGES-1];

endmodule : uart_sync

// File: rtl/uart_rx_frame.sv
// uart_rx_frame
//   UART receiver for the 12-bit frame: start(0), D0..D7 LSB first, parity,
//   two stop bits(1). Samples each bit in its middle, delivers the byte and
//   error flags with a one-cycle Valid pulse. Errors never suppress Valid.
//   Parameters:
//     CLKS_PER_BIT - clk cycles per serial bit (1..1023)
//     SYNC_STAGES  - synchronizer depth on the serial line (2..3)
//   Ports:
//     Clk   - system clock, rising edge
//     Rst_n - synchronous active-low reset
//     bus   - uart_rx_frame_if master modport (Serial_in in, host outputs)
module uart_rx_frame
  import uart_rx_frame_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1,
  parameter int SYNC_STAGES  = 2
) (
  input  logic             Clk,
  input  logic             Rst_n,
  uart_rx_frame_if.master  bus
);

  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] HALF_C = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] LAST_C = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    LAST_IDX = 3'(DATA_BITS - 1);

  // Elaboration-time parameter sanity checks.
  if (CLKS_PER_BIT < 1 || CLKS_PER_BIT > 1023) begin : g_bad_cpb
    $error("uart_rx_frame: CLKS_PER_BIT must be within 1..1023");
  end
  if (SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : g_bad_sync
    $error("uart_rx_frame: SYNC_STAGES must be within 2..3");
  end
  if (FRAME_BITS != DATA_BITS + STOP_BITS + 2) begin : g_bad_frame
    $error("uart_rx_frame: frame geometry constants are inconsistent");
  end

  logic rx;

  uart_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .Clk    (Clk),
    .Rst_n  (Rst_n),
    .async_i(bus.Serial_in),
    .sync_o (rx)
  );

  rx_state_e            state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2:0]           idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 stop1_q, stop1_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      stop1_q <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      stop1_q <= stop1_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    par_d   = par_q;
    stop1_d = stop1_q;
    data_d  = data_q;
    valid_d = 1'b0;
    perr_d  = perr_q;
    ferr_d  = ferr_q;

    unique case (state_q)
      IDLE: begin
        // The cycle that first sees rx low already counts as START cnt=0.
        // When HALF is 0 that cycle is the start sample itself, which is
        // what lets a one-bit-per-clock stream arrive without losing D0.
        if (!rx) begin
          idx_d = '0;
          if (HALF_C == '0) begin
            state_d = DATA;
            cnt_d   = '0;
          end else begin
            state_d = START;
            cnt_d   = CW'(1);
          end
        end
      end

      START: begin
        if (cnt_q == HALF_C) begin
          cnt_d   = '0;
          idx_d   = '0;
          // A line that is high again at mid start bit was a glitch.
          state_d = rx ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      DATA: begin
        if (cnt_q == LAST_C) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx;
          if (idx_q == LAST_IDX) begin
            state_d = PARITY;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      PARITY: begin
        if (cnt_q == LAST_C) begin
          cnt_d   = '0;
          par_d   = rx;
          state_d = STOP1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      STOP1: begin
        if (cnt_q == LAST_C) begin
          cnt_d   = '0;
          stop1_d = rx;
          state_d = STOP2;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      STOP2: begin
        // The second stop bit is taken straight from rx on the completing
        // edge, so the outputs update on the same edge that samples it and
        // the following cycle is already IDLE, ready for a new start bit.
        if (cnt_q == LAST_C) begin
          cnt_d   = '0;
          valid_d = 1'b1;
          data_d  = shift_q;
          perr_d  = (par_q != parity_of(shift_q));
          ferr_d  = ~(stop1_q & rx);
          state_d = rx ? IDLE : WAIT_HIGH;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      WAIT_HIGH: begin
        // Held-low (break) line: wait for it to return high so that the
        // low level is not mistaken for a fresh start bit.
        if (rx) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.Dataout    = data_q;
  assign bus.Valid      = valid_q;
  assign bus.Parity_err = perr_q;
  assign bus.Frame_err  = ferr_q;
  assign bus.Busy       = (state_q != IDLE);

endmodule : uart_rx_frame

// File: tb/tb_uart_rx_frame.sv
// tb_uart_rx_frame
//   Directed bench for uart_rx_frame. Two instances share clk and reset:
//   dut1 runs at CLKS_PER_BIT=1, dut16 at CLKS_PER_BIT=16. Inputs change on
//   the falling edge; Valid pulses are captured 1 time unit after the rising
//   edge and queued; all checks compare against hand-computed values.
module tb_uart_rx_frame;

  logic clk;
  logic rst_n;
  int   cyc;
  int   vectors;
  int   miscompares;
  int   consec;

  uart_rx_frame_if if1 ();
  uart_rx_frame_if if16 ();

  uart_rx_frame #(
    .CLKS_PER_BIT(1),
    .SYNC_STAGES (2)
  ) dut1 (
    .Clk  (clk),
    .Rst_n(rst_n),
    .bus  (if1)
  );

  uart_rx_frame #(
    .CLKS_PER_BIT(16),
    .SYNC_STAGES (2)
  ) dut16 (
    .Clk  (clk),
    .Rst_n(rst_n),
    .bus  (if16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] q1_data[$];
  logic       q1_perr[$];
  logic       q1_ferr[$];
  int         q1_cyc[$];
  logic [7:0] q16_data[$];
  logic       q16_perr[$];
  logic       q16_ferr[$];
  int         q16_cyc[$];

  // Valid capture, one line per received frame.
  initial begin
    logic v1_prev;
    logic v16_prev;
    v1_prev  = 1'b0;
    v16_prev = 1'b0;
    consec   = 0;
    forever begin
      @(posedge clk);
      #1;
      if (if1.Valid === 1'b1) begin
        q1_data.push_back(if1.Dataout);
        q1_perr.push_back(if1.Parity_err);
        q1_ferr.push_back(if1.Frame_err);
        q1_cyc.push_back(cyc);
        $display("rx1  frame: data=%02h parity_err=%0b frame_err=%0b cycle=%0d",
                 if1.Dataout, if1.Parity_err, if1.Frame_err, cyc);
        if (v1_prev) consec++;
      end
      if (if16.Valid === 1'b1) begin
        q16_data.push_back(if16.Dataout);
        q16_perr.push_back(if16.Parity_err);
        q16_ferr.push_back(if16.Frame_err);
        q16_cyc.push_back(cyc);
        $display("rx16 frame: data=%02h parity_err=%0b frame_err=%0b cycle=%0d",
                 if16.Dataout, if16.Parity_err, if16.Frame_err, cyc);
        if (v16_prev) consec++;
      end
      v1_prev  = (if1.Valid === 1'b1);
      v16_prev = (if16.Valid === 1'b1);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input int which, input logic b);
    if (which == 1) if1.Serial_in = b;
    else            if16.Serial_in = b;
  endtask

  // Sends one frame on the chosen line; must be called right after a
  // falling edge. start_cyc is the cycle count when the start bit is driven.
  task automatic send_frame(input int which, input logic [7:0] d, input logic p,
                            input logic s1, input logic s2, output int start_cyc);
    logic [11:0] bits;
    int          cpb;
    bits      = {s2, s1, p, d, 1'b0};
    cpb       = (which == 1) ? 1 : 16;
    start_cyc = cyc;
    for (int i = 0; i < 12; i++) begin
      drive(which, bits[i]);
      repeat (cpb) @(negedge clk);
    end
  endtask

  initial begin
    int sc;
    int sc_a;
    int sc_b;
    vectors     = 0;
    miscompares = 0;
    cyc         = 0;

    // Reset with the line held low.
    rst_n         = 1'b0;
    if1.Serial_in = 1'b0;
    if16.Serial_in = 1'b0;
    idle(5);
    check("rst_dataout",  {24'd0, if1.Dataout}, 32'h00);
    check("rst_valid",    {31'd0, if1.Valid}, 32'h0);
    check("rst_perr",     {31'd0, if1.Parity_err}, 32'h0);
    check("rst_ferr",     {31'd0, if1.Frame_err}, 32'h0);
    check("rst_busy",     {31'd0, if1.Busy}, 32'h0);
    check("rst_busy16",   {31'd0, if16.Busy}, 32'h0);
    rst_n          = 1'b1;
    if1.Serial_in  = 1'b1;
    if16.Serial_in = 1'b1;
    idle(20);
    check("post_rst_nvalid1",  q1_data.size(), 0);
    check("post_rst_nvalid16", q16_data.size(), 0);
    check("post_rst_busy",     {31'd0, if1.Busy}, 32'h0);
    check("post_rst_dataout",  {24'd0, if1.Dataout}, 32'h00);

    // Clean 0xA5: line sequence 0,1,0,1,0,0,1,0,1,0,1,1.
    send_frame(1, 8'hA5, 1'b0, 1'b1, 1'b1, sc);
    drive(1, 1'b1);
    idle(6);
    check("a5_count",   q1_data.size(), 1);
    check("a5_data",    {24'd0, q1_data[0]}, 32'hA5);
    check("a5_perr",    {31'd0, q1_perr[0]}, 32'h0);
    check("a5_ferr",    {31'd0, q1_ferr[0]}, 32'h0);
    // 2 synchronizer edges plus 12 bit times at one clock per bit.
    check("a5_latency", q1_cyc[0] - sc, 14);
    check("a5_held",    {24'd0, if1.Dataout}, 32'hA5);
    check("a5_busy",    {31'd0, if1.Busy}, 32'h0);

    // 0x01 with parity 0 (correct parity would be 1).
    send_frame(1, 8'h01, 1'b0, 1'b1, 1'b1, sc);
    drive(1, 1'b1);
    idle(6);
    check("badpar_count", q1_data.size(), 2);
    check("badpar_data",  {24'd0, q1_data[1]}, 32'h01);
    check("badpar_perr",  {31'd0, q1_perr[1]}, 32'h1);
    check("badpar_ferr",  {31'd0, q1_ferr[1]}, 32'h0);

    // 0x3C, correct parity, STOP2=0, then line held low.
    send_frame(1, 8'h3C, 1'b0, 1'b1, 1'b0, sc);
    idle(10);
    check("frm_count", q1_data.size(), 3);
    check("frm_data",  {24'd0, q1_data[2]}, 32'h3C);
    check("frm_perr",  {31'd0, q1_perr[2]}, 32'h0);
    check("frm_ferr",  {31'd0, q1_ferr[2]}, 32'h1);
    check("frm_busy_low", {31'd0, if1.Busy}, 32'h1);
    idle(5);
    check("frm_no_second_valid", q1_data.size(), 3);
    check("frm_busy_still",      {31'd0, if1.Busy}, 32'h1);
    drive(1, 1'b1);
    idle(5);
    check("frm_busy_released", {31'd0, if1.Busy}, 32'h0);
    check("frm_count_final",   q1_data.size(), 3);
    check("frm_flag_held",     {31'd0, if1.Frame_err}, 32'h1);

    // 4-cycle glitch at 16 clocks per bit.
    drive(16, 1'b0);
    idle(4);
    drive(16, 1'b1);
    idle(40);
    check("glitch_nvalid", q16_data.size(), 0);
    check("glitch_busy",   {31'd0, if16.Busy}, 32'h0);
    check("glitch_data",   {24'd0, if16.Dataout}, 32'h00);

    // Back-to-back 0x00 and 0xFF, no idle gap.
    send_frame(16, 8'h00, 1'b0, 1'b1, 1'b1, sc_a);
    send_frame(16, 8'hFF, 1'b0, 1'b1, 1'b1, sc_b);
    drive(16, 1'b1);
    idle(40);
    check("b2b_count",   q16_data.size(), 2);
    check("b2b_data0",   {24'd0, q16_data[0]}, 32'h00);
    check("b2b_data1",   {24'd0, q16_data[1]}, 32'hFF);
    check("b2b_perr0",   {31'd0, q16_perr[0]}, 32'h0);
    check("b2b_ferr0",   {31'd0, q16_ferr[0]}, 32'h0);
    check("b2b_perr1",   {31'd0, q16_perr[1]}, 32'h0);
    check("b2b_ferr1",   {31'd0, q16_ferr[1]}, 32'h0);
    check("b2b_spacing", q16_cyc[1] - q16_cyc[0], 192);
    // 2 synchronizer edges, HALF=7 plus one, then 11 bit times of 16.
    check("b2b_latency", q16_cyc[0] - sc_a, 186);

    // Reset while dut1 is in DATA with idx=4.
    drive(1, 1'b0);
    idle(1);
    for (int i = 0; i < 6; i++) begin
      drive(1, 1'b1);
      idle(1);
    end
    check("midrst_busy_before", {31'd0, if1.Busy}, 32'h1);
    rst_n = 1'b0;
    idle(3);
    rst_n = 1'b1;
    idle(20);
    check("midrst_nvalid",  q1_data.size(), 3);
    check("midrst_busy",    {31'd0, if1.Busy}, 32'h0);
    check("midrst_dataout", {24'd0, if1.Dataout}, 32'h00);
    send_frame(1, 8'h5A, 1'b0, 1'b1, 1'b1, sc);
    drive(1, 1'b1);
    idle(6);
    check("5a_count", q1_data.size(), 4);
    check("5a_data",  {24'd0, q1_data[3]}, 32'h5A);
    check("5a_perr",  {31'd0, q1_perr[3]}, 32'h0);
    check("5a_ferr",  {31'd0, q1_ferr[3]}, 32'h0);

    check("valid_single_cycle", consec, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_uart_rx_frame

// File: doc/uart_rx_frame.md
Name: uart_rx_frame

Overview:
- UART receiver for the team's 12-bit frame: start(0), D0..D7 LSB first, parity, two stop bits(1).
- The parity bit equals XOR of D0..D7, so the 9 data+parity bits carry an even number of ones.
- Sits at the serial-input pin and presents parallel bytes plus error flags to the host logic.
- Counterpart of the existing transmitter; with CLKS_PER_BIT=1 it accepts that transmitter's one-bit-per-clock stream directly.

Parameters:
- CLKS_PER_BIT, default 1: Clk cycles per serial bit. Legal range is 1..1023.
- SYNC_STAGES, default 2: flip-flop stages on Serial_in. Legal range is 2..3.

Ports:
- Clk  in  1  system clock, all logic on rising edge
- Rst_n  in  1  synchronous active-low reset
- Serial_in  in  1  asynchronous serial line, idle high
- Dataout  out  8  last received byte, D0 in bit 0
- Valid  out  1  one-cycle pulse: a frame completed, Dataout and error flags updated
- Parity_err  out  1  received parity bit != XOR of received data bits; qualified by Valid, held until next Valid
- Frame_err  out  1  either stop bit sampled 0; qualified by Valid, held until next Valid
- Busy  out  1  high in every state except IDLE

Behaviour:
- Reset (Rst_n=0 at a Clk edge):
  - Dataout=0, Valid=0, Parity_err=0, Frame_err=0, Busy=0.
  - State goes to IDLE; counters clear; synchronizer flops are set to 1.
  - Reset mid-frame abandons the frame; no Valid is produced.
- Synchronizer: Serial_in passes through SYNC_STAGES flops. All decisions below use the synchronized value `rx`.
- Timing:
  - HALF = (CLKS_PER_BIT-1)/2, integer division.
  - Bit counter `cnt` has width clog2(CLKS_PER_BIT)+1 and reloads on every sample.
  - Bit index `idx` is 3 bits.
- States and transitions:
  - IDLE: on rx==0 go to START with cnt=0.
  - START: when cnt==HALF, sample rx.
    - rx==1 is a glitch: return to IDLE, no output.
    - rx==0: go to DATA with cnt=0, idx=0.
  - DATA: when cnt==CLKS_PER_BIT-1, shift rx into shift register bit idx and reset cnt.
    - idx==7 goes to PARITY; otherwise idx increments.
  - PARITY: sample rx at cnt==CLKS_PER_BIT-1 into par_bit, then go to STOP1.
  - STOP1: sample at cnt==CLKS_PER_BIT-1 into stop1, then go to STOP2.
  - STOP2: sample at cnt==CLKS_PER_BIT-1 into stop2.
    - On the next edge: Valid=1; Dataout=shift register; Parity_err=(par_bit != ^shift); Frame_err=~(stop1&stop2).
    - Then go to IDLE, or to WAIT_HIGH if rx==0.
  - WAIT_HIGH (break/stuck-low line): stay until rx==1, then go to IDLE. This prevents a false restart on a held-low line.
- Samples land mid-bit because the start sample is at HALF and every later sample is CLKS_PER_BIT cycles after it.
- With CLKS_PER_BIT=1, a start edge at the synchronizer output leads to Valid 12 cycles later.
- Errors do not suppress Valid. The byte is always delivered; the host decides using the flags.
- Back-to-back frames:
  - A start bit immediately after STOP2 is accepted.
  - The IDLE entry cycle counts as START cnt=0, so no bit is lost at CLKS_PER_BIT=1. Implement this as IDLE→START detection in the same cycle as the Valid update.
- Dataout and the flags are stable between Valid pulses. Valid is never high for two consecutive cycles.

Decomposition:
- Shared include uart_defs.vh:
  - state encodings IDLE, START, DATA, PARITY, STOP1, STOP2, WAIT_HIGH;
  - frame constants DATA_BITS=8, STOP_BITS=2, FRAME_BITS=12;
  - parity function (XOR reduction), shared with the transmitter.
- One sub-module: uart_sync, an N-stage reset-to-1 synchronizer parameterized by SYNC_STAGES.
- FSM, counters and output registers stay in uart_rx_frame.

Test Plan:
- Reset value check:
  - Stimulus: hold Rst_n=0 with Serial_in=0 for 5 cycles, then release with Serial_in=1.
  - Required: all outputs 0, Busy=0, no Valid for 20 cycles.
- Clean 0xA5 frame, CLKS_PER_BIT=1:
  - Stimulus: drive 0,1,0,1,0,0,1,0,1,0,1,1.
  - Required: one Valid pulse, Dataout=0xA5, Parity_err=0, Frame_err=0.
- Bad parity:
  - Stimulus: frame carrying data 0x01 with parity bit 0.
  - Required: Valid, Dataout=0x01, Parity_err=1, Frame_err=0.
- Framing error then stuck-low line:
  - Stimulus: frame with data 0x3C and correct parity 0; STOP2=0; line held low 10 bits, then high.
  - Required: Valid with Frame_err=1 and Dataout=0x3C.
  - Required: Busy stays 1 in WAIT_HIGH with no second Valid until the line goes high, then Busy=0.
- Glitch rejection and back-to-back frames, CLKS_PER_BIT=16:
  - Stimulus: a 4-cycle low glitch, then frames 0x00 and 0xFF with no idle gap.
  - Required: no output for the glitch.
  - Required: Valids exactly 192 cycles apart, Dataout 0x00 then 0xFF, both flags 0.
- Reset mid-frame:
  - Stimulus: assert Rst_n=0 during DATA idx=4, release, then send 0x5A.
  - Required: no Valid for the aborted frame; a single Valid with Dataout=0x5A.
